// File: rtl/ckt3_pkg.sv
// ==== ckt3_pkg: shared width default and result record for the unit-3 adder leaf. Rev 1.0 ====
`default_nettype none

package ckt3_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Result record at the default width, for downstream consumers that bundle adder outputs.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] sum;
    logic                     cout;
    logic                     ovf;
  } result_t;

  function automatic result_t pack_result(input logic [DEFAULT_WIDTH-1:0] sum,
                                          input logic cout,
                                          input logic ovf);
    result_t r;
    r.sum  = sum;
    r.cout = cout;
    r.ovf  = ovf;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ckt3_ripple_adder_fa_cell.sv
// ==== fa_cell: one-bit full adder, the ripple element of ckt3_ripple_adder. Rev 1.0 ====
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

`default_nettype wire

// File: rtl/ckt3_ripple_adder.sv
// ==== ckt3_ripple_adder: ripple-carry adder, registered sum/cout/ovf, 1-cycle latency. Rev 1.0 ====
`default_nettype none

module ckt3_ripple_adder
  import ckt3_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_valid;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_carry[i]),
      .s  (w_sum[i]),
      .co (w_carry[i+1])
    );
  end

  // Signed overflow: carry into the MSB cell disagrees with the carry out of it.
  assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign s         = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_ckt3_ripple_adder.sv
// ==== tb_ckt3_ripple_adder: directed self-checking bench for the 4-bit adder. Rev 1.0 ====
`default_nettype none

module tb_ckt3_ripple_adder;

  localparam int c_width = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [c_width-1:0] a;
  logic [c_width-1:0] b;
  logic               cin;
  logic [c_width-1:0] s;
  logic               cout;
  logic               ovf;
  logic               out_valid;

  int checks = 0;
  int errors = 0;

  ckt3_ripple_adder #(.WIDTH(c_width)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int es, input logic ec,
                           input logic eo, input logic ev);
    check({tag, ".s"},         32'(s),         32'(es));
    check({tag, ".cout"},      32'(cout),      32'(ec));
    check({tag, ".ovf"},       32'(ovf),       32'(eo));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
  endtask

  task automatic drive(input logic r, input logic v, input int va, input int vb, input logic c);
    rst      = r;
    in_valid = v;
    a        = c_width'(va);
    b        = c_width'(vb);
    cin      = c;
  endtask

  // Inputs settle well before the edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b1, 15, 15, 1'b0);
    tick(); check_out("reset1", 0, 1'b0, 1'b0, 1'b0);
    tick(); check_out("reset2", 0, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 1'b1, 6, 3, 1'b0);
    tick(); check_out("6+3", 9, 1'b0, 1'b1, 1'b1);

    drive(1'b0, 1'b1, 12, 3, 1'b0);
    tick(); check_out("12+3", 15, 1'b0, 1'b0, 1'b1);

    drive(1'b0, 1'b1, 12, 5, 1'b0);
    tick(); check_out("12+5", 1, 1'b1, 1'b0, 1'b1);

    drive(1'b0, 1'b1, 12, 5, 1'b1);
    tick(); check_out("12+5+1", 2, 1'b1, 1'b0, 1'b1);

    drive(1'b0, 1'b1, 15, 15, 1'b1);
    tick(); check_out("15+15+1", 15, 1'b1, 1'b0, 1'b1);

    drive(1'b0, 1'b0, 0, 0, 1'b0);
    tick(); check_out("hold1", 15, 1'b1, 1'b0, 1'b0);
    tick(); check_out("hold2", 15, 1'b1, 1'b0, 1'b0);
    tick(); check_out("hold3", 15, 1'b1, 1'b0, 1'b0);

    drive(1'b0, 1'b1, 0, 0, 1'b0);
    tick(); check_out("0+0", 0, 1'b0, 1'b0, 1'b1);

    // -8 + -8: wraps to 0 with both carry-out and signed overflow set
    drive(1'b0, 1'b1, 8, 8, 1'b0);
    tick(); check_out("8+8", 0, 1'b1, 1'b1, 1'b1);

    drive(1'b0, 1'b1, 7, 1, 1'b0);
    tick(); check_out("7+1pre", 8, 1'b0, 1'b1, 1'b1);

    drive(1'b1, 1'b1, 7, 1, 1'b0);
    tick(); check_out("midrst", 0, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 1'b1, 7, 1, 1'b0);
    tick(); check_out("7+1", 8, 1'b0, 1'b1, 1'b1);

    drive(1'b0, 1'b0, 3, 3, 1'b1);
    tick(); check_out("hold4", 8, 1'b0, 1'b1, 1'b0);

    drive(1'b0, 1'b1, 9, 6, 1'b1);
    tick(); check_out("9+6+1", 0, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ckt3_ripple_adder.md
Name: ckt3_ripple_adder

Overview:
- Parameterizable ripple-carry adder with registered outputs; 4-bit by default.
- Adds operands a and b plus carry-in cin through a chain of one-bit full-adder cells.
- Presents sum, carry-out and signed-overflow one clock after the operands are accepted.
- Used as the basic arithmetic leaf for the unit-3 datapath exercises.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in_valid  input  1  qualifies a, b and cin for the current cycle.
- a  input  WIDTH  addend A, unsigned (also read as two's-complement for ovf).
- b  input  WIDTH  addend B, unsigned (also read as two's-complement for ovf).
- cin  input  1  carry into bit 0.
- s  output  WIDTH  registered sum, (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry out of the MSB cell.
- ovf  output  1  registered signed overflow, carry into MSB XOR carry out of MSB.
- out_valid  output  1  high for exactly one cycle per accepted operand set.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: when rst is high at a clk edge, s=0, cout=0, ovf=0 and out_valid=0 on the next cycle.
  - rst overrides in_valid in the same cycle.
  - Any result in flight is discarded.
- Combinational core: carry c[0]=cin.
  - For bit i: sum_i = a[i]^b[i]^c[i].
  - c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])).
  - No lookahead; pure ripple.
- Latency: exactly 1 cycle.
  - Operands sampled with in_valid=1 at edge k appear on s, cout and ovf after edge k.
  - out_valid=1 in that same cycle.
- Hold: when in_valid=0 at an edge, s, cout and ovf keep their previous values and out_valid goes to 0.
- Throughput: one operation per cycle; back-to-back in_valid accepted with no bubbles.
- No backpressure: there is no ready signal and the block is always able to accept.
- Width rules:
  - {cout, s} equals the full (WIDTH+1)-bit result of a+b+cin.
  - Maximum is 2^(WIDTH+1)-1 (31 for WIDTH=4) with a=b=all-ones and cin=1.
- Wrap-around: results of 2^WIDTH or more wrap in s, and cout=1.
- Overflow:
  - ovf=1 exactly when a and b have equal MSBs and s's MSB differs from them (with cin included).
  - ovf is independent of cout.
- X-handling: there are no internal state-machine states; the only state is the output registers.

Decomposition:
- Shared package ckt3_pkg:
  - localparam DEFAULT_WIDTH=4.
  - typedef struct result_t {sum, cout, ovf} for downstream consumers.
- One sub-module, fa_cell: one-bit full adder (a, b, ci -> s, co).
  - Instantiated WIDTH times via a generate loop and chained carry-to-carry.
- The output register stage stays in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=15, b=15 -> s=0, cout=0, ovf=0, out_valid=0 throughout.
- a=6, b=3, cin=0, in_valid=1 -> next cycle s=9 (1001), cout=0, ovf=1, out_valid=1.
- a=12, b=3, cin=0 -> s=15 (1111), cout=0, ovf=0.
- a=12, b=5, cin=0 -> s=1 (0001), cout=1, ovf=0.
  - Then a=12, b=5, cin=1 on the following cycle -> s=2 (0010), cout=1, ovf=0.
  - Confirms back-to-back issue.
- Hold and corners:
  - Result a=15, b=15, cin=1 -> s=15, cout=1.
  - Then in_valid=0 for 3 cycles with a=0 -> s stays 15, cout stays 1, out_valid=0.
  - Then a=0, b=0, cin=0 -> s=0, cout=0.
- Mid-stream reset: apply in_valid=1 with a=7, b=1 and rst=1 in the same cycle -> outputs 0, out_valid=0.
  - Next accepted a=7, b=1, cin=0 -> s=8, cout=0, ovf=1.
